// File: rtl/bitsieve_pkg.sv
// Shared constants, FSM state type and the tie-break LFSR step for the
// BitSieve flip scheduler.
package bitsieve_pkg;

  localparam int N_SPINS  = 1024;
  localparam int IDX_W    = 10;
  localparam int WORD_W   = 32;
  localparam int LFSR_W   = 16;
  localparam int STREAK_W = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Galois right-shift mask for taps 16,14,13,11.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int LANE_W  = $clog2(WORD_W);
  localparam int N_WORDS = N_SPINS / WORD_W;
  localparam int WCNT_W  = $clog2(N_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  // One Galois step; a nonzero state never reaches zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/bitsieve_word_tree.sv
// Combinational randomized 2:1 reduction of one accept word to a single lane.
// Level 0 pairs adjacent lanes; level k is steered by rnd_i[k]. Side A of
// every node is the lower-index child.
module bitsieve_word_tree
  import bitsieve_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [LANE_W-1:0] rnd_i,
  output logic [LANE_W-1:0] lane_o,
  output logic              valid_o
);

  // In-place tournament: node n of a level overwrites slot n with the
  // result of slots 2n and 2n+1 (both still unread at that point).
  always_comb begin : tree
    logic [WORD_W-1:0] v;
    logic [LANE_W-1:0] ix [WORD_W];
    logic              a_v, b_v;
    logic [LANE_W-1:0] a_i, b_i;
    v   = word_i;
    a_v = 1'b0;
    b_v = 1'b0;
    a_i = '0;
    b_i = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ix[i] = LANE_W'(i);
    end
    for (int l = 0; l < LANE_W; l++) begin
      for (int n = 0; n < WORD_W / 2; n++) begin
        if (n < (WORD_W >> (l + 1))) begin
          a_v  = v[2*n];
          b_v  = v[2*n+1];
          a_i  = ix[2*n];
          b_i  = ix[2*n+1];
          v[n] = a_v | b_v;
          if (a_v && b_v)  ix[n] = rnd_i[l] ? a_i : b_i;
          else if (a_v)    ix[n] = a_i;
          else if (b_v)    ix[n] = b_i;
          else             ix[n] = '0;
        end
      end
    end
    valid_o = v[0];
    lane_o  = ix[0];
  end

endmodule

// File: rtl/bitsieve_flip_scheduler.sv
// One BitSieve selection round: stream WORD_W-bit accept words, reduce each
// with a randomized tree, merge into a running winner and hand one flip index
// (or "no flip") to the spin-update unit.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds valid and its payload stable until that
// edge, and ready never depends combinationally on valid.
module bitsieve_flip_scheduler
  import bitsieve_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                acc_valid,
  output logic                acc_ready,
  input  logic [WORD_W-1:0]   acc_word,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  output logic                flip_valid,
  input  logic                flip_ready,
  output logic [IDX_W-1:0]    flip_idx,
  output logic                flip_none,
  output logic                busy,
  output logic [STREAK_W-1:0] none_streak
);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(N_WORDS - 1);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                best_v_q, best_v_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic [LANE_W-1:0]   tree_lane;
  logic                tree_v;
  logic [IDX_W-1:0]    word_idx;

  bitsieve_word_tree u_tree (
    .word_i  (acc_word),
    .rnd_i   (lfsr_q[LANE_W-1:0]),
    .lane_o  (tree_lane),
    .valid_o (tree_v)
  );

  // Global spin index of the word winner.
  assign word_idx    = {word_cnt_q, tree_lane};
  assign busy        = (state_q != IDLE);
  assign none_streak = streak_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      best_v_q   <= 1'b0;
      best_idx_q <= '0;
      lfsr_q     <= LFSR_SEED;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      best_v_q   <= best_v_d;
      best_idx_q <= best_idx_d;
      lfsr_q     <= lfsr_d;
      streak_q   <= streak_d;
    end
  end

  // Next-state, merge and handshake outputs.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    best_v_d   = best_v_q;
    best_idx_d = best_idx_q;
    lfsr_d     = lfsr_q;
    streak_d   = streak_q;
    acc_ready  = 1'b0;
    flip_valid = 1'b0;
    flip_idx   = '0;
    flip_none  = 1'b0;
    case (state_q)
      IDLE: begin
        // Seed lands this edge, so a simultaneous start uses it for word 0.
        if (seed_load) begin
          lfsr_d = (seed == '0) ? LFSR_SEED : seed;
        end
        if (start) begin
          best_v_d   = 1'b0;
          best_idx_d = '0;
          word_cnt_d = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        acc_ready = 1'b1;
        if (acc_valid) begin
          if (tree_v && !(best_v_q && lfsr_q[LANE_W])) begin
            best_v_d   = 1'b1;
            best_idx_d = word_idx;
          end
          lfsr_d     = lfsr_next(lfsr_q);
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        flip_valid = 1'b1;
        flip_idx   = best_idx_q;
        flip_none  = !best_v_q;
        if (flip_ready) begin
          state_d = IDLE;
          if (best_v_q)            streak_d = '0;
          else if (streak_q != '1) streak_d = streak_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
